// File: rtl/ps2_pkg.sv
// Shared constants, sequencer state type and the ASCII -> PS/2 set-2 make-code table.
package ps2_pkg;

  localparam logic [7:0]  PS2_BREAK      = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    StIdle,
    StMake,
    StGap1,
    StBrk,
    StGap2,
    StCode
  } seq_state_e;

  // Returns {hit, code}; hit=0 means the character has no scancode.
  function automatic logic [8:0] ascii2scan(input logic [7:0] ch);
    logic [7:0] code;
    logic       hit;
    hit  = 1'b1;
    code = 8'h00;
    case (ch)
      8'h61: code = 8'h1C;
      8'h62: code = 8'h32;
      8'h63: code = 8'h21;
      8'h64: code = 8'h23;
      8'h65: code = 8'h24;
      8'h66: code = 8'h2B;
      8'h67: code = 8'h34;
      8'h68: code = 8'h33;
      8'h69: code = 8'h43;
      8'h6A: code = 8'h3B;
      8'h6B: code = 8'h42;
      8'h6C: code = 8'h4B;
      8'h6D: code = 8'h3A;
      8'h6E: code = 8'h31;
      8'h6F: code = 8'h44;
      8'h70: code = 8'h4D;
      8'h71: code = 8'h15;
      8'h72: code = 8'h2D;
      8'h73: code = 8'h1B;
      8'h74: code = 8'h2C;
      8'h75: code = 8'h3C;
      8'h76: code = 8'h2A;
      8'h77: code = 8'h1D;
      8'h78: code = 8'h22;
      8'h79: code = 8'h35;
      8'h7A: code = 8'h1A;
      8'h30: code = 8'h45;
      8'h31: code = 8'h16;
      8'h32: code = 8'h1E;
      8'h33: code = 8'h26;
      8'h34: code = 8'h25;
      8'h35: code = 8'h2E;
      8'h36: code = 8'h36;
      8'h37: code = 8'h3D;
      8'h38: code = 8'h3E;
      8'h39: code = 8'h46;
      default: hit = 1'b0;
    endcase
    return {hit, code};
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// One-byte PS/2 device-to-host serializer: start, 8 data bits LSB first, odd parity, stop.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic       ps2_clk_o,
  output logic       ps2_data_o
);

  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [3:0]      BitLast = 4'(PS2_FRAME_BITS - 1);

  logic            busy_q, busy_d;
  logic            low_q, low_d;
  logic [DivW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [10:0]     frame_q, frame_d;
  logic            clk_q, clk_d;
  logic            data_q, data_d;
  logic            phase_end;

  always_comb begin
    busy_d    = busy_q;
    low_d     = low_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    clk_d     = clk_q;
    data_d    = data_q;
    phase_end = busy_q && (cnt_q == DivLast);
    done_o    = phase_end && low_q && (bit_q == BitLast);

    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        frame_d = {1'b1, ~^byte_i, byte_i, 1'b0};
        cnt_d   = '0;
        low_d   = 1'b0;
        bit_d   = '0;
        clk_d   = 1'b1;
        data_d  = 1'b0;
      end
    end else if (phase_end) begin
      cnt_d = '0;
      if (!low_q) begin
        low_d = 1'b1;
        clk_d = 1'b0;
      end else begin
        // Bit boundary: data only moves here, while the clock goes back high.
        low_d = 1'b0;
        clk_d = 1'b1;
        if (bit_q == BitLast) begin
          busy_d = 1'b0;
          bit_d  = '0;
          data_d = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          frame_d = {1'b1, frame_q[10:1]};
          data_d  = frame_q[1];
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      low_q   <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      clk_q   <= 1'b1;
      data_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
    end
  end

  assign ps2_clk_o  = clk_q;
  assign ps2_data_o = data_q;

endmodule

// File: rtl/ps2_ascii_sender.sv
// PS/2 keyboard emulator: per accepted ASCII char sends make code, F0, make code.
module ps2_ascii_sender
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ascii,
  input  logic       valid,
  output logic       ready,
  output logic       err,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [7:0]      code_q, code_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [8:0]      scan;
  logic            tx_start;
  logic            tx_done;
  logic [7:0]      tx_byte;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    gap_d    = gap_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    tx_start = 1'b0;
    tx_byte  = code_q;
    scan     = ascii2scan(ascii);

    unique case (state_q)
      StIdle: begin
        if (valid && ready_q) begin
          if (scan[8]) begin
            // Serializer starts in the same edge so the start bit appears next cycle.
            tx_start = 1'b1;
            tx_byte  = scan[7:0];
            code_d   = scan[7:0];
            ready_d  = 1'b0;
            state_d  = StMake;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StMake: begin
        if (tx_done) begin
          gap_d   = '0;
          state_d = StGap1;
        end
      end
      StGap1: begin
        if (gap_q == GapLast) begin
          tx_start = 1'b1;
          tx_byte  = PS2_BREAK;
          state_d  = StBrk;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StBrk: begin
        if (tx_done) begin
          gap_d   = '0;
          state_d = StGap2;
        end
      end
      StGap2: begin
        if (gap_q == GapLast) begin
          tx_start = 1'b1;
          state_d  = StCode;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StCode: begin
        if (tx_done) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      code_q  <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  ps2_frame_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_frame_tx (
    .clk_i     (clk),
    .rst_ni    (clrn),
    .start_i   (tx_start),
    .byte_i    (tx_byte),
    .done_o    (tx_done),
    .ps2_clk_o (ps2_clk),
    .ps2_data_o(ps2_data)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ps2_ascii_sender.sv
// Bench for ps2_ascii_sender: PS/2 host model on ps2_clk fall plus a table-based reference.
module tb_ps2_ascii_sender;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Gap    = 8;
  localparam int          Busy   = 66 * ClkDiv + 2 * Gap;

  // Make codes for 'a'..'z' then '0'..'9'.
  localparam logic [7:0] ScTable [36] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };

  logic       clk   = 1'b0;
  logic       clrn  = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       ready;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;

  int checks   = 0;
  int failures = 0;

  ps2_ascii_sender #(
    .CLK_DIV   (ClkDiv),
    .GAP_CYCLES(Gap)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .ascii   (ascii),
    .valid   (valid),
    .ready   (ready),
    .err     (err),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] char_of(input int idx);
    if (idx < 26) return 8'(8'h61 + idx);
    return 8'(8'h30 + idx - 26);
  endfunction

  function automatic logic [8:0] ref_scan(input logic [7:0] ch);
    for (int i = 0; i < 36; i++) begin
      if (char_of(i) == ch) return {1'b1, ScTable[i]};
    end
    return 9'h000;
  endfunction

  function automatic bit odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Host model: collects frames on falling ps2_clk; a reset discards any partial frame.
  logic [7:0] rx_byte [$];
  bit         rx_par  [$];
  bit         rx_ok   [$];
  int         hbits = 0;
  logic [10:0] hsh;
  int         falls = 0;

  always @(negedge ps2_clk or negedge clrn) begin
    if (!clrn) begin
      hbits = 0;
    end else begin
      falls++;
      hsh[hbits] = ps2_data;
      hbits++;
      if (hbits == 11) begin
        rx_byte.push_back(hsh[8:1]);
        rx_par.push_back(hsh[9]);
        rx_ok.push_back(hsh[0] == 1'b0 && hsh[10] == 1'b1);
        hbits = 0;
      end
    end
  end

  // Line monitor: idle-high runs ending in a start bit, data changes while clock low, err pulses.
  int   runs [$];
  int   idle_run = 0;
  int   viol = 0;
  int   err_cnt = 0;
  logic prev_data = 1'b1;

  always @(negedge clk) begin
    if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
      idle_run++;
    end else begin
      if (idle_run > 0 && ps2_clk === 1'b1 && ps2_data === 1'b0) runs.push_back(idle_run);
      idle_run = 0;
    end
    if (ps2_data !== prev_data && ps2_clk !== 1'b1) viol++;
    prev_data = ps2_data;
    if (err === 1'b1) err_cnt++;
  end

  int b_rx, b_falls, b_runs, b_err, b_viol;

  task automatic snap();
    b_rx    = rx_byte.size();
    b_falls = falls;
    b_runs  = runs.size();
    b_err   = err_cnt;
    b_viol  = viol;
  endtask

  task automatic do_send(input logic [7:0] ch, output int busy, output bit err_at,
                         output bit timeout);
    @(negedge clk);
    valid = 1'b1;
    ascii = ch;
    @(posedge clk);
    @(negedge clk);
    valid  = 1'b0;
    ascii  = 8'($urandom);
    err_at = err;
    busy   = 0;
    while (ready !== 1'b1 && busy < 2000) begin
      busy++;
      @(negedge clk);
    end
    timeout = (busy >= 2000);
  endtask

  task automatic test_reset();
    int bad;
    clrn = 1'b1;
    #2 clrn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) begin
      failures++;
      $display("FAIL reset_in: got %b want 1011", {ready, err, ps2_clk, ps2_data});
    end
    clrn = 1'b1;
    snap();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({ready, err, ps2_clk, ps2_data} !== 4'b1011) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (falls - b_falls !== 0) begin
      failures++;
      $display("FAIL reset_falls: got %0d want 0", falls - b_falls);
    end
  endtask

  task automatic test_char_a();
    logic [7:0] exp [3];
    int busy;
    bit ea, to, gap_ok;
    exp = '{8'h1C, 8'hF0, 8'h1C};
    snap();
    do_send(8'h61, busy, ea, to);
    checks++;
    if (to || busy !== Busy) begin
      failures++;
      $display("FAIL a_busy: got %0d want %0d", busy, Busy);
    end
    checks++;
    if (rx_byte.size() - b_rx !== 3) begin
      failures++;
      $display("FAIL a_frames: got %0d want 3", rx_byte.size() - b_rx);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_byte[b_rx+i] !== exp[i] || rx_par[b_rx+i] !== odd_par(exp[i]) ||
            rx_ok[b_rx+i] !== 1'b1) begin
          failures++;
          $display("FAIL a_frame%0d: got %h par %b ok %b want %h par %b ok 1", i,
                   rx_byte[b_rx+i], rx_par[b_rx+i], rx_ok[b_rx+i], exp[i], odd_par(exp[i]));
        end
      end
    end
    gap_ok = (runs.size() - b_runs == 3);
    for (int i = b_runs + 1; i < runs.size(); i++) if (runs[i] < Gap) gap_ok = 1'b0;
    checks++;
    if (!gap_ok) begin
      failures++;
      $display("FAIL a_gap: got %0d starts, gaps below %0d present", runs.size() - b_runs, Gap);
    end
    checks++;
    if (falls - b_falls !== 33 || viol - b_viol !== 0 || err_cnt - b_err !== 0) begin
      failures++;
      $display("FAIL a_lines: got falls %0d viol %0d err %0d want 33 0 0", falls - b_falls,
               viol - b_viol, err_cnt - b_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [6];
    int busy1, busy2, falls7, n7;
    exp = '{8'h3D, 8'hF0, 8'h3D, 8'h1A, 8'hF0, 8'h1A};
    snap();
    @(negedge clk);
    valid = 1'b1;
    ascii = 8'h37;
    @(posedge clk);
    @(negedge clk);
    ascii = 8'h7A;
    busy1 = 0;
    while (ready !== 1'b1 && busy1 < 2000) begin
      busy1++;
      @(negedge clk);
    end
    falls7 = falls - b_falls;
    n7     = rx_byte.size() - b_rx;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    ascii = 8'($urandom);
    busy2 = 0;
    while (ready !== 1'b1 && busy2 < 2000) begin
      busy2++;
      @(negedge clk);
    end
    checks++;
    if (busy1 !== Busy || busy2 !== Busy) begin
      failures++;
      $display("FAIL b2b_busy: got %0d/%0d want %0d", busy1, busy2, Busy);
    end
    checks++;
    if (falls7 !== 33 || n7 !== 3) begin
      failures++;
      $display("FAIL b2b_7count: got falls %0d frames %0d want 33 3", falls7, n7);
    end
    checks++;
    if (rx_byte.size() - b_rx !== 6) begin
      failures++;
      $display("FAIL b2b_frames: got %0d want 6", rx_byte.size() - b_rx);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_byte[b_rx+i] !== exp[i] || rx_ok[b_rx+i] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_frame%0d: got %h ok %b want %h ok 1", i, rx_byte[b_rx+i],
                   rx_ok[b_rx+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] chars [2];
    int busy, low;
    bit ea, to;
    chars = '{8'h41, 8'h00};
    for (int k = 0; k < 2; k++) begin
      snap();
      do_send(chars[k], busy, ea, to);
      low = 0;
      repeat (20) begin
        @(negedge clk);
        if (ready !== 1'b1) low++;
      end
      checks++;
      if (ea !== 1'b1 || err_cnt - b_err !== 1) begin
        failures++;
        $display("FAIL inv_err%0d: got err_at %b pulses %0d want 1 1", k, ea, err_cnt - b_err);
      end
      checks++;
      if (busy !== 0 || low !== 0 || falls - b_falls !== 0) begin
        failures++;
        $display("FAIL inv_idle%0d: got busy %0d low %0d falls %0d want 0 0 0", k, busy, low,
                 falls - b_falls);
      end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] exp [3];
    int busy;
    exp = '{8'h21, 8'hF0, 8'h21};
    snap();
    @(negedge clk);
    valid = 1'b1;
    ascii = 8'h63;
    @(posedge clk);
    @(negedge clk);
    busy = 0;
    while (ready !== 1'b1 && busy < 2000) begin
      busy++;
      ascii = char_of($urandom_range(0, 35));
      if (busy >= Busy - 10) valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    checks++;
    if (busy !== Busy) begin
      failures++;
      $display("FAIL ign_busy: got %0d want %0d", busy, Busy);
    end
    checks++;
    if (rx_byte.size() - b_rx !== 3) begin
      failures++;
      $display("FAIL ign_frames: got %0d want 3", rx_byte.size() - b_rx);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_byte[b_rx+i] !== exp[i] || rx_ok[b_rx+i] !== 1'b1) begin
          failures++;
          $display("FAIL ign_frame%0d: got %h want %h", i, rx_byte[b_rx+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_midreset();
    logic [7:0] exp [3];
    int busy;
    bit ea, to;
    exp = '{8'h32, 8'hF0, 8'h32};
    snap();
    @(negedge clk);
    valid = 1'b1;
    ascii = char_of($urandom_range(0, 35));
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    // Break frame starts 22*ClkDiv+Gap cycles in; land inside its bit 5.
    repeat (22 * ClkDiv + Gap + 5 * 2 * ClkDiv + 1) @(negedge clk);
    checks++;
    if (rx_byte.size() - b_rx !== 1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre: got frames %0d ready %b want 1 0", rx_byte.size() - b_rx, ready);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if ({ready, ps2_clk, ps2_data} !== 3'b111) begin
      failures++;
      $display("FAIL mid_reset: got %b want 111", {ready, ps2_clk, ps2_data});
    end
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    do_send(8'h62, busy, ea, to);
    checks++;
    if (busy !== Busy) begin
      failures++;
      $display("FAIL mid_busy: got %0d want %0d", busy, Busy);
    end
    checks++;
    if (rx_byte.size() - b_rx !== 3) begin
      failures++;
      $display("FAIL mid_frames: got %0d want 3", rx_byte.size() - b_rx);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_byte[b_rx+i] !== exp[i] || rx_ok[b_rx+i] !== 1'b1) begin
          failures++;
          $display("FAIL mid_frame%0d: got %h want %h", i, rx_byte[b_rx+i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ch;
    logic [8:0] rs;
    logic [7:0] exp [3];
    int busy;
    bit ea, to;
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) ch = char_of($urandom_range(0, 35));
      else ch = 8'($urandom);
      rs = ref_scan(ch);
      exp = '{rs[7:0], 8'hF0, rs[7:0]};
      snap();
      do_send(ch, busy, ea, to);
      if (rs[8]) begin
        checks++;
        if (busy !== Busy || ea !== 1'b0 || rx_byte.size() - b_rx !== 3) begin
          failures++;
          $display("FAIL rnd_txn %h: got busy %0d err %b frames %0d want %0d 0 3", ch, busy, ea,
                   rx_byte.size() - b_rx, Busy);
        end else begin
          for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_byte[b_rx+i] !== exp[i] || rx_par[b_rx+i] !== odd_par(exp[i]) ||
                rx_ok[b_rx+i] !== 1'b1) begin
              failures++;
              $display("FAIL rnd_frame %h/%0d: got %h par %b want %h par %b", ch, i,
                       rx_byte[b_rx+i], rx_par[b_rx+i], exp[i], odd_par(exp[i]));
            end
          end
        end
      end else begin
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 0 || ea !== 1'b1 || err_cnt - b_err !== 1 || falls - b_falls !== 0) begin
          failures++;
          $display("FAIL rnd_inv %h: got busy %0d err %b pulses %0d falls %0d want 0 1 1 0", ch,
                   busy, ea, err_cnt - b_err, falls - b_falls);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_back_to_back();
    test_invalid();
    test_ignore();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
